// File: rtl/regdst_hazard_ctrl.sv
// Decode-stage destination select and RAW hazard/stall control for a 5-stage pipeline.
// Define REGDST_FORWARD_EN to add EX/MEM forwarding selects and restrict stalls to load-use.
module regdst_hazard_ctrl #(
   parameter int REG_W    = 5,
   parameter int LINK_REG = 31,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [5:0]       id_op,
   input  logic [5:0]       id_funct,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             flush,
   output logic [1:0]       reg_dst_sel,
   output logic [REG_W-1:0] id_dest,
   output logic             id_wen,
   output logic             stall,
   output logic [REG_W-1:0] wb_dest,
   output logic             wb_wen,
   output logic [CNT_W-1:0] stall_cnt
`ifdef REGDST_FORWARD_EN
   ,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [1:0] SEL_RT   = 2'b00;
   localparam logic [1:0] SEL_RD   = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;

   localparam logic [REG_W-1:0] ZERO_REG  = {REG_W{1'b0}};
   localparam logic [REG_W-1:0] LINK_DEST = REG_W'(LINK_REG);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   // Raw decode before the $0-destination squash
   logic             raw_wen_s;
   logic [1:0]       raw_sel_s;
   logic [REG_W-1:0] raw_dest_s;
   logic             reads_rs_s;
   logic             reads_rt_s;
   logic             id_wen_s;
   logic [REG_W-1:0] id_dest_s;
   logic [1:0]       id_sel_s;

   // In-flight destination pipeline
   logic             ex_wen_q,  ex_wen_d;
   logic [REG_W-1:0] ex_dest_q, ex_dest_d;
   logic             mem_wen_q;
   logic [REG_W-1:0] mem_dest_q;
   logic             wb_wen_q;
   logic [REG_W-1:0] wb_dest_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             rs_ex_s, rt_ex_s, rs_mem_s, rt_mem_s;
   logic             stall_s;
   logic             issue_s;

`ifdef REGDST_FORWARD_EN
   logic             raw_load_s;
   logic             id_load_s;
   logic             ex_load_q, ex_load_d;
   logic [1:0]       fwd_a_s, fwd_b_s;
`endif

   function automatic logic src_hit(input logic             wen,
                                    input logic [REG_W-1:0] dest,
                                    input logic [REG_W-1:0] src);
      return wen & (dest == src) & (src != ZERO_REG);
   endfunction

   // Instruction classification: write enable, destination, and which sources are read
   always_comb begin
      raw_wen_s  = 1'b0;
      raw_sel_s  = SEL_RT;
      raw_dest_s = ZERO_REG;
      reads_rs_s = 1'b0;
      reads_rt_s = 1'b0;
`ifdef REGDST_FORWARD_EN
      raw_load_s = 1'b0;
`endif
      if (id_valid) begin
         case (id_op)
            OP_RTYPE: begin
               reads_rs_s = 1'b1;
               if (id_funct != FN_JR) begin
                  raw_wen_s  = 1'b1;
                  raw_sel_s  = SEL_RD;
                  raw_dest_s = id_rd;
                  reads_rt_s = 1'b1;
               end else begin
                  reads_rt_s = 1'b0;
               end
            end
            OP_LW: begin
               raw_wen_s  = 1'b1;
               raw_dest_s = id_rt;
               reads_rs_s = 1'b1;
`ifdef REGDST_FORWARD_EN
               raw_load_s = 1'b1;
`endif
            end
            OP_SW, OP_BEQ, OP_BNE: begin
               reads_rs_s = 1'b1;
               reads_rt_s = 1'b1;
            end
            OP_JAL: begin
               raw_wen_s  = 1'b1;
               raw_sel_s  = SEL_LINK;
               raw_dest_s = LINK_DEST;
            end
            default: begin
               // Immediate ALU group 0x08..0x0F
               if (id_op[5:3] == 3'b001) begin
                  raw_wen_s  = 1'b1;
                  raw_dest_s = id_rt;
                  reads_rs_s = 1'b1;
               end else begin
                  raw_wen_s  = 1'b0;
               end
            end
         endcase
      end else begin
         raw_wen_s = 1'b0;
      end
   end

   // A write to $0 is architecturally a no-op, so it never counts as a writer
   assign id_wen_s  = raw_wen_s & (raw_dest_s != ZERO_REG);
   assign id_dest_s = id_wen_s ? raw_dest_s : ZERO_REG;
   assign id_sel_s  = id_wen_s ? raw_sel_s : SEL_RT;
`ifdef REGDST_FORWARD_EN
   assign id_load_s = raw_load_s & id_wen_s;
`endif

   assign rs_ex_s  = reads_rs_s & src_hit(ex_wen_q,  ex_dest_q,  id_rs);
   assign rt_ex_s  = reads_rt_s & src_hit(ex_wen_q,  ex_dest_q,  id_rt);
   assign rs_mem_s = reads_rs_s & src_hit(mem_wen_q, mem_dest_q, id_rs);
   assign rt_mem_s = reads_rt_s & src_hit(mem_wen_q, mem_dest_q, id_rt);

`ifdef REGDST_FORWARD_EN
   // Only a load still in EX cannot be bypassed
   assign stall_s = id_valid & ~flush & ex_load_q & (rs_ex_s | rt_ex_s);

   // Forwarding selects; the younger EX result wins over MEM
   always_comb begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
      if (rs_ex_s) begin
         fwd_a_s = 2'b10;
      end else if (rs_mem_s) begin
         fwd_a_s = 2'b01;
      end else begin
         fwd_a_s = 2'b00;
      end
      if (rt_ex_s) begin
         fwd_b_s = 2'b10;
      end else if (rt_mem_s) begin
         fwd_b_s = 2'b01;
      end else begin
         fwd_b_s = 2'b00;
      end
   end

   assign fwd_a = fwd_a_s;
   assign fwd_b = fwd_b_s;
`else
   assign stall_s = id_valid & ~flush & (rs_ex_s | rt_ex_s | rs_mem_s | rt_mem_s);
`endif

   assign issue_s = id_valid & ~stall_s & ~flush;

   // Next EX entry and saturating stall counter
   always_comb begin
      ex_wen_d  = 1'b0;
      ex_dest_d = ZERO_REG;
`ifdef REGDST_FORWARD_EN
      ex_load_d = 1'b0;
`endif
      cnt_d     = cnt_q;
      if (issue_s) begin
         ex_wen_d  = id_wen_s;
         ex_dest_d = id_dest_s;
`ifdef REGDST_FORWARD_EN
         ex_load_d = id_load_s;
`endif
      end else begin
         ex_wen_d  = 1'b0;
         ex_dest_d = ZERO_REG;
      end
      if (stall_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Stage registers: EX <= ID (or bubble), MEM <= EX, WB <= MEM
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_wen_q   <= 1'b0;
         ex_dest_q  <= ZERO_REG;
         mem_wen_q  <= 1'b0;
         mem_dest_q <= ZERO_REG;
         wb_wen_q   <= 1'b0;
         wb_dest_q  <= ZERO_REG;
         cnt_q      <= {CNT_W{1'b0}};
`ifdef REGDST_FORWARD_EN
         ex_load_q  <= 1'b0;
`endif
      end else begin
         ex_wen_q   <= ex_wen_d;
         ex_dest_q  <= ex_dest_d;
         mem_wen_q  <= ex_wen_q;
         mem_dest_q <= ex_dest_q;
         wb_wen_q   <= mem_wen_q;
         wb_dest_q  <= mem_dest_q;
         cnt_q      <= cnt_d;
`ifdef REGDST_FORWARD_EN
         ex_load_q  <= ex_load_d;
`endif
      end
   end

   assign reg_dst_sel = id_sel_s;
   assign id_dest     = id_dest_s;
   assign id_wen      = id_wen_s;
   assign stall       = stall_s;
   assign wb_dest     = wb_dest_q;
   assign wb_wen      = wb_wen_q;
   assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_regdst_hazard_ctrl.sv
// Bench for regdst_hazard_ctrl: directed vector table, multi-cycle sequences and
// randomized traffic checked against an instruction-history reference model.
module tb_regdst_hazard_ctrl;

   localparam int REG_W = 5;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid;
   logic [5:0]       id_op;
   logic [5:0]       id_funct;
   logic [REG_W-1:0] id_rs, id_rt, id_rd;
   logic             flush;
   logic [1:0]       reg_dst_sel;
   logic [REG_W-1:0] id_dest;
   logic             id_wen;
   logic             stall;
   logic [REG_W-1:0] wb_dest;
   logic             wb_wen;
   logic [CNT_W-1:0] stall_cnt;
`ifdef REGDST_FORWARD_EN
   logic [1:0]       fwd_a, fwd_b;
`endif

   regdst_hazard_ctrl #(.REG_W(REG_W), .LINK_REG(31), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .reg_dst_sel(reg_dst_sel), .id_dest(id_dest), .id_wen(id_wen), .stall(stall),
      .wb_dest(wb_dest), .wb_wen(wb_wen), .stall_cnt(stall_cnt)
`ifdef REGDST_FORWARD_EN
      , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: history of what entered EX on each past cycle, newest first
   typedef struct { int wen; int dest; int ld; } ent_t;
   ent_t hist[$];
   ent_t nxt;
   int   model_cnt;
   int   e_sel, e_dest, e_wen, e_stall, e_wbw, e_wbd, e_fa, e_fb, e_issue;

   function automatic int busy(ent_t e, int s);
      return (s != 0 && e.wen != 0 && e.dest == s) ? 1 : 0;
   endfunction

   task automatic model_clear();
      ent_t z;
      z = '{0, 0, 0};
      hist.delete();
      for (int i = 0; i < 3; i++) hist.push_back(z);
      model_cnt = 0;
   endtask

   task automatic model_eval();
      int w, sel, dst, ra, rb, ld, op, a_ex, a_mem, b_ex, b_mem;
      w = 0; sel = 0; dst = 0; ra = 0; rb = 0; ld = 0;
      op = int'(id_op);
      if (id_valid) begin
         if (op == 0 && id_funct != 6'h08) begin w = 1; sel = 1; dst = int'(id_rd); ra = 1; rb = 1; end
         else if (op == 0) ra = 1;
         else if (op >= 8 && op <= 15) begin w = 1; dst = int'(id_rt); ra = 1; end
         else if (op == 'h23) begin w = 1; dst = int'(id_rt); ra = 1; ld = 1; end
         else if (op == 'h2B || op == 4 || op == 5) begin ra = 1; rb = 1; end
         else if (op == 3) begin w = 1; sel = 2; dst = 31; end
      end
      if (dst == 0) w = 0;
      if (w == 0) begin dst = 0; sel = 0; ld = 0; end
      a_ex  = ra * busy(hist[0], int'(id_rs));
      a_mem = ra * busy(hist[1], int'(id_rs));
      b_ex  = rb * busy(hist[0], int'(id_rt));
      b_mem = rb * busy(hist[1], int'(id_rt));
`ifdef REGDST_FORWARD_EN
      e_stall = (id_valid && !flush && hist[0].ld != 0 && (a_ex + b_ex) > 0) ? 1 : 0;
`else
      e_stall = (id_valid && !flush && (a_ex + a_mem + b_ex + b_mem) > 0) ? 1 : 0;
`endif
      e_fa    = a_ex ? 2 : (a_mem ? 1 : 0);
      e_fb    = b_ex ? 2 : (b_mem ? 1 : 0);
      e_sel   = sel;
      e_dest  = dst;
      e_wen   = w;
      e_wbw   = hist[2].wen;
      e_wbd   = hist[2].dest;
      e_issue = (id_valid && !flush && e_stall == 0) ? 1 : 0;
      nxt     = '{w, dst, ld};
   endtask

   task automatic model_cmp();
      chk("reg_dst_sel", 32'(reg_dst_sel), 32'(e_sel));
      chk("id_dest",     32'(id_dest),     32'(e_dest));
      chk("id_wen",      32'(id_wen),      32'(e_wen));
      chk("stall",       32'(stall),       32'(e_stall));
      chk("wb_wen",      32'(wb_wen),      32'(e_wbw));
      chk("wb_dest",     32'(wb_dest),     32'(e_wbd));
      chk("stall_cnt",   32'(stall_cnt),   32'(model_cnt));
`ifdef REGDST_FORWARD_EN
      chk("fwd_a", 32'(fwd_a), 32'(e_fa));
      chk("fwd_b", 32'(fwd_b), 32'(e_fb));
`endif
   endtask

   // Advance one clock; the model applies the same edge
   task automatic adv();
      ent_t z;
      z = '{0, 0, 0};
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         hist.push_front(e_issue ? nxt : z);
         void'(hist.pop_back());
         if (e_stall != 0 && model_cnt < (1 << CNT_W) - 1) model_cnt++;
      end
      #1;
   endtask

   task automatic set_in(input int r, input int v, input int op, input int fn,
                         input int s, input int t, input int d, input int fl);
      rst = r[0]; id_valid = v[0]; id_op = 6'(op); id_funct = 6'(fn);
      id_rs = 5'(s); id_rt = 5'(t); id_rd = 5'(d); flush = fl[0];
   endtask

   typedef struct {
      int r, v, op, fn, s, t, d, fl;
      int sel, dest, wen, stl, wbw, wbd, cnt;
   } vec_t;
   vec_t tbl[19];

   int ops[15] = '{0, 0, 0, 8, 13, 15, 'h23, 'h23, 'h2B, 4, 5, 3, 2, 'h10, 'h3F};

   initial begin
      //            r  v  op  fn  s  t  d fl | sel dst wen stl wbw wbd cnt
      tbl[0]  = '{0, 0, 0,    0, 0, 0, 0, 0,   0,  0, 0, 0, 0,  0, 0};
      tbl[1]  = '{0, 1, 0,   32, 1, 2, 3, 0,   1,  3, 1, 0, 0,  0, 0};
      tbl[2]  = '{0, 0, 0,    0, 0, 0, 0, 0,   0,  0, 0, 0, 0,  0, 0};
      tbl[3]  = '{0, 0, 0,    0, 0, 0, 0, 0,   0,  0, 0, 0, 0,  0, 0};
      tbl[4]  = '{0, 0, 0,    0, 0, 0, 0, 0,   0,  0, 0, 0, 1,  3, 0};
      tbl[5]  = '{0, 1, 3,    0, 7, 8, 9, 0,   2, 31, 1, 0, 0,  0, 0};
      tbl[6]  = '{0, 1, 8,    0, 1, 0, 0, 0,   0,  0, 0, 0, 0,  0, 0};
      tbl[7]  = '{0, 1, 0,   32, 0, 0, 5, 0,   1,  5, 1, 0, 0,  0, 0};
      tbl[8]  = '{0, 0, 0,    0, 0, 0, 0, 0,   0,  0, 0, 0, 1, 31, 0};
      tbl[9]  = '{0, 1, 0,   32, 1, 2, 3, 0,   1,  3, 1, 0, 0,  0, 0};
      tbl[10] = '{0, 1, 0,   34, 3, 5, 4, 0,   1,  4, 1, 1, 1,  5, 0};
      tbl[11] = '{0, 1, 0,   34, 3, 5, 4, 0,   1,  4, 1, 1, 0,  0, 1};
      tbl[12] = '{0, 1, 0,   34, 3, 5, 4, 0,   1,  4, 1, 0, 1,  3, 2};
      tbl[13] = '{0, 1, 'h23, 0, 4, 6, 0, 1,   0,  6, 1, 0, 0,  0, 2};
      tbl[14] = '{0, 1, 0,   32, 6, 0, 7, 0,   1,  7, 1, 0, 0,  0, 2};
      tbl[15] = '{0, 1, 'h2B, 0, 7, 2, 0, 0,   0,  0, 0, 1, 1,  4, 2};
      tbl[16] = '{1, 1, 'h2B, 0, 7, 2, 0, 0,   0,  0, 0, 1, 0,  0, 3};
      tbl[17] = '{0, 1, 'h2B, 0, 7, 2, 0, 0,   0,  0, 0, 0, 0,  0, 0};
      tbl[18] = '{0, 1, 2,    0, 3, 4, 5, 0,   0,  0, 0, 0, 0,  0, 0};

      model_clear();
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      model_eval();
      adv();

`ifndef REGDST_FORWARD_EN
      for (int i = 0; i < 19; i++) begin
         set_in(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].fn, tbl[i].s, tbl[i].t, tbl[i].d, tbl[i].fl);
         @(negedge clk);
         chk($sformatf("v%0d.sel", i),   32'(reg_dst_sel), 32'(tbl[i].sel));
         chk($sformatf("v%0d.dest", i),  32'(id_dest),     32'(tbl[i].dest));
         chk($sformatf("v%0d.wen", i),   32'(id_wen),      32'(tbl[i].wen));
         chk($sformatf("v%0d.stall", i), 32'(stall),       32'(tbl[i].stl));
         chk($sformatf("v%0d.wbw", i),   32'(wb_wen),      32'(tbl[i].wbw));
         chk($sformatf("v%0d.wbd", i),   32'(wb_dest),     32'(tbl[i].wbd));
         chk($sformatf("v%0d.cnt", i),   32'(stall_cnt),   32'(tbl[i].cnt));
         model_eval();
         adv();
      end
`else
      // Load-use: one stall, then MEM forwarding
      set_in(0, 1, 'h23, 0, 1, 3, 0, 0); @(negedge clk); model_eval(); adv();
      set_in(0, 1, 0, 32, 3, 5, 4, 0);   @(negedge clk);
      chk("lu.stall", 32'(stall), 32'd1);
      model_eval(); adv();
      @(negedge clk);
      chk("lu.stall2", 32'(stall), 32'd0);
      chk("lu.fwd_a",  32'(fwd_a), 32'd1);
      model_eval(); adv();
      // ALU-ALU: no stall, both operands from EX
      set_in(0, 1, 0, 32, 1, 2, 3, 0);   @(negedge clk); model_eval(); adv();
      set_in(0, 1, 0, 32, 3, 3, 4, 0);   @(negedge clk);
      chk("aa.stall", 32'(stall), 32'd0);
      chk("aa.fwd_a", 32'(fwd_a), 32'd2);
      chk("aa.fwd_b", 32'(fwd_b), 32'd2);
      model_eval(); adv();
`endif

      for (int n = 0; n < 800; n++) begin
         int op, fn;
         op = ops[$urandom_range(0, 14)];
         fn = ($urandom_range(0, 5) == 0) ? 8 : 32;
         set_in(($urandom_range(0, 49) == 0) ? 1 : 0,
                ($urandom_range(0, 9) != 0) ? 1 : 0,
                op, fn,
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                ($urandom_range(0, 9) == 0) ? 1 : 0);
         @(negedge clk);
         model_eval();
         model_cmp();
         adv();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
